// File: rtl/apb_slv_regbank_pkg.sv
// Shared types and helpers for the APB slave register bank.
// Width helpers derive byte-lane and word-index geometry from the data width.
package apb_slv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam int ID_INDEX = 0;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int idx_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_slv_regbank_mem.sv
// Flop-array word storage with byte-lane write port and asynchronous read port.
// Out-of-range read indices return zero; reset clears every word.
module apb_slv_mem #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IDX_WIDTH-1:0]    widx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IDX_WIDTH-1:0]    ridx,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (widx == IDX_WIDTH'(i)) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wstrb[b]) mem_q[i][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Index compare instead of direct array select keeps the index width free of DEPTH.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ridx == IDX_WIDTH'(i)) rdata = mem_q[i];
    end
  end

endmodule

// File: rtl/apb_slv_regbank.sv
// APB4 slave register bank: read-only ID at index 0, byte-strobe storage elsewhere,
// programmable wait states and PSLVERR on out-of-range or ID writes. All outputs registered.
module apb_slv_regbank
  import apb_slv_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [63:0] ID_VALUE    = 64'hA5B0_0001
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSELx,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int STRB_WIDTH = strb_width(DATA_WIDTH);
  localparam int IDX_LSB    = idx_lsb(DATA_WIDTH);
  localparam int IDX_WIDTH  = ADDR_WIDTH - IDX_LSB;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [DATA_WIDTH-1:0] ID_WORD = ID_VALUE[DATA_WIDTH-1:0];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic                  mem_we;
  logic [IDX_WIDTH-1:0]  paddr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] mem_rdata, resp_data;
  logic                  setup, setup_err, resp_err, resp_wr;

  if (IDX_LSB > 0) begin : g_offset
    logic unused_offset;
    assign unused_offset = ^PADDR[IDX_LSB-1:0];
  end

  assign paddr_idx = PADDR[ADDR_WIDTH-1:IDX_LSB];
  assign setup     = PSELx && !PENABLE;
  assign setup_err = (32'(paddr_idx) >= 32'(DEPTH)) ||
                     (PWRITE && (paddr_idx == IDX_WIDTH'(ID_INDEX)));

  // With no wait states the response is formed from the live bus at the setup edge.
  assign rd_idx    = (state_q == IDLE) ? paddr_idx : idx_q;
  assign resp_err  = (state_q == IDLE) ? setup_err : err_q;
  assign resp_wr   = (state_q == IDLE) ? PWRITE    : wr_q;
  assign resp_data = (resp_err || resp_wr)             ? '0      :
                     (rd_idx == IDX_WIDTH'(ID_INDEX)) ? ID_WORD : mem_rdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    err_d     = err_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup) begin
          wr_d    = PWRITE;
          err_d   = setup_err;
          idx_d   = paddr_idx;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          if (WAIT_CYCLES == 0) begin
            state_d   = READY;
            pready_d  = 1'b1;
            pslverr_d = resp_err;
            prdata_d  = resp_data;
          end else begin
            cnt_d   = WAIT_LD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!PSELx) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d   = READY;
            pready_d  = 1'b1;
            pslverr_d = resp_err;
            prdata_d  = resp_data;
          end
        end
      end
      READY: begin
        if (PSELx && PENABLE) begin
          mem_we    = wr_q && !err_q;
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (!PSELx) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  apb_slv_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_mem (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (mem_we),
    .widx  (idx_q),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .ridx  (rd_idx),
    .rdata (mem_rdata)
  );

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slv_regbank.sv
// Bench for apb_slv_regbank: three instances (0, 2 and 3 wait states) share one APB bus,
// each with its own select; expected responses are queued and checked by a monitor.
module tb_apb_slv_regbank;

  logic        PCLK;
  logic        PRESETn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata [3];
  logic [2:0]  pready;
  logic [2:0]  pslverr;

  // Entry layout: {is_read, pslverr, prdata}
  logic [33:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slv_regbank #(
      .WAIT_CYCLES ((g == 0) ? 0 : g + 1)
    ) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .PSELx   (psel[g]),
      .PENABLE (penable),
      .PWRITE  (pwrite),
      .PADDR   (paddr),
      .PWDATA  (pwdata),
      .PSTRB   (pstrb),
      .PRDATA  (prdata[g]),
      .PREADY  (pready[g]),
      .PSLVERR (pslverr[g])
    );
  end

  // Clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic monitor();
    logic [33:0] e;
    forever begin
      @(negedge PCLK);
      for (int i = 0; i < 3; i++) begin
        if (psel[i] && penable && pready[i]) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected completion on dut%0d: got PREADY=1 expected no transfer", i);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("pslverr dut%0d a%03h", i, paddr), {63'd0, pslverr[i]}, {63'd0, e[32]});
            if (e[33]) chk($sformatf("prdata dut%0d a%03h", i, paddr), {32'd0, prdata[i]}, {32'd0, e[31:0]});
          end
        end
      end
    end
  endtask

  // Driver: one full APB transfer on instance s, checking the number of wait cycles.
  task automatic xfer(input int s, input bit wr, input logic [9:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input bit eerr, input logic [31:0] edata,
                      input int ewaits);
    int waits;
    exp_q.push_back({~wr, eerr, (wr ? 32'h0 : edata)});
    @(posedge PCLK); #1;
    psel    = '0;
    psel[s] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    pstrb   = st;
    @(posedge PCLK); #1;
    penable = 1'b1;
    waits = 0;
    while (!pready[s] && waits < 40) begin
      @(posedge PCLK); #1;
      waits++;
    end
    chk($sformatf("wait cycles dut%0d a%03h", s, addr), 64'(waits), 64'(ewaits));
    @(posedge PCLK); #1;
    psel    = '0;
    penable = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s PREADY dut%0d", tag, i),  {63'd0, pready[i]},  64'd0);
      chk($sformatf("%s PSLVERR dut%0d", tag, i), {63'd0, pslverr[i]}, 64'd0);
      chk($sformatf("%s PRDATA dut%0d", tag, i),  {32'd0, prdata[i]},  64'd0);
    end
  endtask

  initial begin
    PRESETn = 1'b0;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge PCLK);
    #1;
    chk_idle_outputs("reset");
    PRESETn = 1'b1;

    // Zero wait states: write then read back
    xfer(0, 1, 10'h004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 0);
    xfer(0, 0, 10'h004, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 0);
    // Two wait states: ID register
    xfer(1, 0, 10'h000, 32'h0, 4'h0, 0, 32'hA5B0_0001, 2);
    // Partial strobes; low address bits ignored
    xfer(0, 1, 10'h008, 32'h1122_3344, 4'hF, 0, 32'h0, 0);
    xfer(0, 1, 10'h008, 32'hAABB_CCDD, 4'b0101, 0, 32'h0, 0);
    xfer(0, 0, 10'h008, 32'h0, 4'h0, 0, 32'h11BB_33DD, 0);
    xfer(0, 0, 10'h00B, 32'h0, 4'hF, 0, 32'h11BB_33DD, 0);
    // Empty strobe completes without change or error
    xfer(0, 1, 10'h004, 32'h1234_5678, 4'h0, 0, 32'h0, 0);
    xfer(0, 0, 10'h004, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 0);
    // Errors: ID write, out-of-range read and write
    xfer(0, 1, 10'h000, 32'hFFFF_FFFF, 4'hF, 1, 32'h0, 0);
    xfer(0, 0, 10'h000, 32'h0, 4'h0, 0, 32'hA5B0_0001, 0);
    xfer(0, 0, 10'h100, 32'h0, 4'h0, 1, 32'h0, 0);
    xfer(1, 1, 10'h3FC, 32'h0123_4567, 4'hF, 1, 32'h0, 2);
    // Last valid index
    xfer(1, 1, 10'h0FC, 32'h5A5A_A5A5, 4'hF, 0, 32'h0, 2);
    xfer(1, 0, 10'h0FC, 32'h0, 4'h0, 0, 32'h5A5A_A5A5, 2);
    // Three wait states
    xfer(2, 1, 10'h014, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 3);
    xfer(2, 0, 10'h014, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 3);

    // Abort after one access cycle
    @(posedge PCLK); #1;
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 10'h00C; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK); #1;
    chk("abort PREADY during wait", {63'd0, pready[2]}, 64'd0);
    psel = '0; penable = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("abort PREADY after drop", {63'd0, pready[2]}, 64'd0);
    xfer(2, 0, 10'h00C, 32'h0, 4'h0, 0, 32'h0, 3);

    // PENABLE without a setup phase is ignored
    @(posedge PCLK); #1;
    psel = 3'b001; penable = 1'b1; pwrite = 1'b0; paddr = 10'h004;
    repeat (2) @(posedge PCLK);
    #1;
    chk("no-setup PREADY", {63'd0, pready[0]}, 64'd0);
    psel = '0; penable = 1'b0;

    // Reset mid-transfer: dut0 already READY, dut2 in WAIT
    @(posedge PCLK); #1;
    psel = 3'b101; penable = 1'b0; pwrite = 1'b1; paddr = 10'h010; pwdata = 32'h7777_8888; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    chk("pre-reset PREADY dut0", {63'd0, pready[0]}, 64'd1);
    #1;
    PRESETn = 1'b0;
    #1;
    chk_idle_outputs("async reset");
    @(posedge PCLK); #1;
    psel = '0; penable = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    xfer(0, 0, 10'h004, 32'h0, 4'h0, 0, 32'h0, 0);
    xfer(0, 0, 10'h010, 32'h0, 4'h0, 0, 32'h0, 0);
    xfer(2, 0, 10'h010, 32'h0, 4'h0, 0, 32'h0, 3);
    xfer(2, 0, 10'h014, 32'h0, 4'h0, 0, 32'h0, 3);

    repeat (2) @(posedge PCLK);
    chk("expected queue drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_slv_regbank.md
Name: apb_slv_regbank

Overview:
Parametrised APB4 slave register bank: DEPTH words of DATA_WIDTH bits with byte-strobe writes, programmable wait states and PSLVERR signalling.
Index 0 is a read-only ID register; all other indices are read/write storage.
Sits behind the APB interconnect as the DUT for the APB slave UVM environment. It replaces the fixed-width slave and adds wait states, byte strobes and error responses.

Parameters:
ADDR_WIDTH, 10, PADDR width in bits; byte address.
DATA_WIDTH, 32, PWDATA/PRDATA width in bits; must be 8, 16, 32 or 64.
DEPTH, 64, number of words; must be ≤ 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
WAIT_CYCLES, 0, access-phase cycles with PREADY=0 before completion; 0 to 15.
ID_VALUE, 32'hA5B0_0001, value returned by index 0, zero-extended or truncated to DATA_WIDTH.

Ports:
PCLK  in  1  clock; all state changes on rising edge.
PRESETn  in  1  reset; asynchronous assert, active-low.
PSELx  in  1  slave select.
PENABLE  in  1  access phase.
PWRITE  in  1  1 = write, 0 = read.
PADDR  in  ADDR_WIDTH  byte address; word index = PADDR[ADDR_WIDTH-1:log2(DATA_WIDTH/8)].
PWDATA  in  DATA_WIDTH  write data.
PSTRB  in  DATA_WIDTH/8  write byte lanes.
PRDATA  out  DATA_WIDTH  read data; valid when PREADY=1 and PWRITE=0.
PREADY  out  1  transfer completion.
PSLVERR  out  1  error response; valid only when PREADY=1.

Behaviour:
- Reset (PRESETn=0, asynchronous):
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - FSM goes to IDLE; wait counter = 0.
  - All storage words cleared to 0.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, WAIT, READY.
- IDLE:
  - Setup edge (PSELx=1, PENABLE=0) latches PWRITE, word index, PWDATA and PSTRB, and evaluates the error condition.
  - If WAIT_CYCLES=0: go to READY at that edge, setting PREADY=1, PSLVERR and PRDATA.
  - Otherwise: load counter=WAIT_CYCLES and go to WAIT.
  - PENABLE=1 seen in IDLE without a preceding setup edge: ignored, stay IDLE, PREADY stays 0.
- WAIT:
  - Counter decrements on each edge with PSELx=1.
  - At the edge where counter==1: go to READY, setting PREADY=1, PSLVERR and PRDATA.
  - PSELx=0 in WAIT (abort): go to IDLE, counter=0, no write.
- READY:
  - Completion edge (PSELx=PENABLE=PREADY=1):
    - Write performed if PWRITE=1 and no error.
    - Next state IDLE; PREADY, PSLVERR and PRDATA return to 0.
  - PSELx=0 in READY: go to IDLE with no write.
- Latency: the transfer completes WAIT_CYCLES+1 cycles after the setup edge.
  - Back-to-back transfers need the APB setup phase, so the minimum is 2 cycles per transfer.
- Error condition (PSLVERR=1 with PREADY):
  - word index ≥ DEPTH, or
  - write to index 0.
  - On error: no storage change, PRDATA=0.
- Write:
  - Byte lane k is updated iff PSTRB[k]=1.
  - PSTRB=0 completes with no change and no error.
  - PADDR low byte-offset bits are ignored.
- Read:
  - PSTRB is ignored.
  - Index 0 returns ID_VALUE.
  - Other indices return the stored word as it was at the setup edge; no write can intervene.
- Reset mid-transfer: outputs clear immediately; the in-flight write is lost.

Decomposition:
- Package apb_slv_pkg:
  - state enum (IDLE, WAIT, READY);
  - localparams STRB_WIDTH=DATA_WIDTH/8, IDX_LSB=log2(STRB_WIDTH), IDX_WIDTH, ID_INDEX=0.
- Sub-module apb_slv_mem:
  - DEPTH×DATA_WIDTH flop array;
  - byte-strobe write port, asynchronous read port;
  - reset clears the array.
- Top level holds the FSM, wait counter, error decode and output registers.

Test Plan:
- WAIT_CYCLES=0: write 32'hDEAD_BEEF to 0x004 with PSTRB=4'hF, then read 0x004 -> PREADY high on the first access cycle; PRDATA=32'hDEAD_BEEF; PSLVERR=0.
- WAIT_CYCLES=2: read 0x000 -> PREADY low for 2 access cycles, high on the 3rd; PRDATA=32'hA5B0_0001; PSLVERR=0.
- Partial strobe: write 32'h1122_3344 to 0x008 with PSTRB=4'hF, then 32'hAABB_CCDD with PSTRB=4'b0101, then read 0x008 -> 32'h11BB_33DD.
- Errors:
  - write 0x000 -> PSLVERR=1 and ID unchanged on readback;
  - read 0x100 (index 64) -> PSLVERR=1, PRDATA=0.
- Abort: with WAIT_CYCLES=3, write 0x00C and drop PSELx after 1 access cycle -> no PREADY; readback of 0x00C = 0.
- Reset: assert PRESETn=0 during the WAIT of a write to 0x010 -> PREADY/PSLVERR/PRDATA go to 0 asynchronously; after release, 0x004 and 0x010 read 0.
